uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_tx.sv | 169 ++++++++++++++++
 tb/tb_uart_tx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the default baud divisor.
// The transmitter state set grows a PARITY state when UART_TX_PARITY_EN is defined.
package uart_pkg;

  // 50 MHz system clock / 115200 baud
  localparam int UART_CLKS_PER_BIT = 434;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// clear forces the count back to 0 so a new state always starts a full bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wrap at the end of each bit period, or restart on request.
  always_comb begin
    bit_done = (cnt_q == LAST);
    if (clear || bit_done) cnt_d = '0;
    else                   cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits. A one-entry holding buffer allows gapless back-to-back frames.
// Optional feature macro: UART_TX_PARITY_EN (adds a parity bit, PARITY_ODD selects odd).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_enable,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       tx_buf_full,
  output logic       tx_busy,
  output logic       tx_line
);

  uart_tx_state_t state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] shift_q, shift_d;
  logic       buf_full_q, buf_full_d;
  logic       tx_line_q, tx_line_d;
  logic       busy_q, busy_d;
  logic       accept, load, clear, bit_done;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;

  function automatic logic parity_of(input logic [7:0] b);
    logic p;
    p = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) p ^= b[i];
    return p ^ PARITY_ODD;
  endfunction
`endif

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .bit_done (bit_done)
  );

  // Next-state, buffer handshake and next serial line level.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    hold_d     = hold_q;
    shift_d    = shift_q;
    buf_full_d = buf_full_q;
    load       = 1'b0;
    accept     = data_valid & tx_enable & ~buf_full_q;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (buf_full_q && tx_enable) begin
          state_d = START;
          load    = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d   = STOP;
          bit_idx_d = '0;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            bit_idx_d = '0;
            if (buf_full_q && tx_enable) begin
              state_d = START;
              load    = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Load drains the buffer; accept only happens while it is empty, so they never coincide.
    if (load) begin
      shift_d    = hold_q;
      buf_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d      = parity_of(hold_q);
`endif
    end
    if (accept) begin
      hold_d     = data;
      buf_full_d = 1'b1;
    end

    case (state_d)
      START:   tx_line_d = 1'b0;
      DATA:    tx_line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_line_d = par_d;
`endif
      default: tx_line_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
    clear  = (state_d != state_q) || (state_q == IDLE);
  end

  // FSM and registered outputs; payload registers carry no reset.
  always_ff @(posedge clk) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
    if (rst) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      buf_full_q <= 1'b0;
      tx_line_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      buf_full_q <= buf_full_d;
      tx_line_q  <= tx_line_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_line     = tx_line_q;
  assign tx_busy     = busy_q;
  assign tx_buf_full = buf_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=4, 8 data bits, 1 stop bit.
// Honors UART_TX_PARITY_EN (even parity) when defined.
module tb_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_enable = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx_buf_full, tx_busy, tx_line;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];
  bit obs_q[$];
  bit busy_q[$];
  bit full_q[$];

  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_enable   (tx_enable),
    .data        (data),
    .data_valid  (data_valid),
    .tx_buf_full (tx_buf_full),
    .tx_busy     (tx_busy),
    .tx_line     (tx_line)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference: a frame is a list of bit levels, each held C cycles; line idles high.
  function automatic void model_frame(input logic [7:0] b);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[k]) for (int r = 0; r < C; r++) exp_q.push_back(bits[k]);
  endfunction

  function automatic bit exp_at(input int i);
    return (i < exp_q.size()) ? exp_q[i] : 1'b1;
  endfunction

  function automatic int line_diff();
    foreach (obs_q[i]) if (obs_q[i] != exp_at(i)) return i;
    return -1;
  endfunction

  function automatic int count_ones(input bit q[$], input int lo, input int hi);
    int n = 0;
    for (int i = lo; i < hi && i < q.size(); i++) n += q[i];
    return n;
  endfunction

  task automatic clear_q();
    exp_q.delete(); obs_q.delete(); busy_q.delete(); full_q.delete();
  endtask

  task automatic push_sample();
    obs_q.push_back(tx_line);
    busy_q.push_back(tx_busy);
    full_q.push_back(tx_buf_full);
  endtask

  task automatic sample_n(input int n);
    repeat (n) begin
      @(negedge clk);
      push_sample();
    end
  endtask

  // Write byte b, then wait (bounded) for the frame to start and the buffer to drain.
  task automatic write_and_wait_start(input logic [7:0] b, input string tag);
    int n;
    @(negedge clk); data = b; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0;
    n = 0;
    while (tx_buf_full === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL %s_start_timeout buf_full=%0b expected 0", tag, tx_buf_full);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL reset_tx_line got %0b expected 1", tx_line); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy got %0b expected 0", tx_busy); end
    checks++; if (tx_buf_full !== 1'b0) begin errors++; $display("FAIL reset_buf_full got %0b expected 0", tx_buf_full); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame(input logic [7:0] b);
    int d;
    clear_q();
    @(negedge clk); data = b; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0; data = 8'($urandom);
    checks++;
    if (tx_buf_full !== 1'b1 || tx_line !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL accept_cycle full=%0b line=%0b busy=%0b expected 1 1 0", tx_buf_full, tx_line, tx_busy);
    end
    model_frame(b);
    sample_n(FLEN + 8);
    d = line_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL frame_%h idx %0d tx_line=%0b expected %0b", b, d, obs_q[d], exp_at(d));
    end
    checks++;
    if (obs_q[0] !== 1'b0) begin errors++; $display("FAIL first_low_latency got %0b expected 0", obs_q[0]); end
    checks++;
    if (count_ones(busy_q, 0, busy_q.size()) != FLEN || busy_q[0] !== 1'b1 || busy_q[FLEN] !== 1'b0) begin
      errors++;
      $display("FAIL busy_len got %0d expected %0d", count_ones(busy_q, 0, busy_q.size()), FLEN);
    end
  endtask

  task automatic test_back_to_back();
    int d, lows;
    clear_q();
    write_and_wait_start(8'h00, "b2b");
    model_frame(8'h00);
    model_frame(8'hFF);
    push_sample();
    data = 8'hFF; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0; push_sample();
    sample_n(2 * FLEN + 6);
    d = line_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL b2b_stream idx %0d tx_line=%0b expected %0b", d, obs_q[d], exp_at(d)); end
    lows = FLEN - count_ones(full_q, 0, FLEN);
    checks++;
    if (lows != 1 || full_q[0] !== 1'b0 || full_q[FLEN] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_buf_full lows=%0d first=%0b at_second=%0b expected 1 0 0", lows, full_q[0], full_q[FLEN]);
    end
    checks++;
    if (count_ones(busy_q, 0, 2 * FLEN) != 2 * FLEN) begin
      errors++;
      $display("FAIL b2b_busy got %0d expected %0d", count_ones(busy_q, 0, 2 * FLEN), 2 * FLEN);
    end
  endtask

  task automatic test_drop();
    logic [7:0] a, b, c, e;
    int d;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); e = 8'($urandom);
    clear_q();
    write_and_wait_start(a, "drop");
    model_frame(a);
    model_frame(b);
    push_sample();
    data = b; data_valid = 1'b1;
    @(negedge clk); push_sample(); data = c;
    @(negedge clk); push_sample(); data = e;
    @(negedge clk); push_sample(); data_valid = 1'b0;
    sample_n(3 * FLEN + 4);
    d = line_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL drop_stream idx %0d tx_line=%0b expected %0b", d, obs_q[d], exp_at(d)); end
    checks++;
    if (count_ones(busy_q, 0, busy_q.size()) != 2 * FLEN) begin
      errors++;
      $display("FAIL drop_busy got %0d expected %0d", count_ones(busy_q, 0, busy_q.size()), 2 * FLEN);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d;
    clear_q();
    write_and_wait_start(8'($urandom), "rstmid");
    data = 8'($urandom); data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL rstmid_line got %0b expected 1", tx_line); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b expected 0", tx_busy); end
    checks++; if (tx_buf_full !== 1'b0) begin errors++; $display("FAIL rstmid_full got %0b expected 0", tx_buf_full); end
    rst = 1'b0;
    sample_n(2 * FLEN);
    d = line_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL rstmid_idle idx %0d tx_line=%0b expected 1", d, obs_q[d]); end
    checks++;
    if (count_ones(busy_q, 0, busy_q.size()) != 0) begin
      errors++;
      $display("FAIL rstmid_busy_after got %0d expected 0", count_ones(busy_q, 0, busy_q.size()));
    end
  endtask

  task automatic test_enable();
    logic [7:0] a, b;
    int d;
    a = 8'($urandom); b = 8'($urandom);
    // Disabled: writes are dropped.
    clear_q();
    tx_enable = 1'b0;
    @(negedge clk); data = 8'($urandom); data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0;
    sample_n(12);
    tx_enable = 1'b1;
    sample_n(4);
    d = line_diff();
    checks++;
    if (d != -1 || count_ones(full_q, 0, full_q.size()) != 0) begin
      errors++;
      $display("FAIL en_off_write idx %0d full_count %0d expected -1 0", d, count_ones(full_q, 0, full_q.size()));
    end
    // Drop enable mid-frame: frame completes, buffered byte is held.
    clear_q();
    write_and_wait_start(a, "en");
    model_frame(a);
    push_sample();
    data = b; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0; push_sample();
    sample_n(8);
    tx_enable = 1'b0;
    sample_n(FLEN + 20);
    d = line_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL en_mid_stream idx %0d tx_line=%0b expected %0b", d, obs_q[d], exp_at(d)); end
    checks++;
    if (full_q[full_q.size() - 1] !== 1'b1 || busy_q[busy_q.size() - 1] !== 1'b0) begin
      errors++;
      $display("FAIL en_held full=%0b busy=%0b expected 1 0", full_q[full_q.size() - 1], busy_q[busy_q.size() - 1]);
    end
    // Re-enable: held byte goes out starting next cycle.
    clear_q();
    model_frame(b);
    tx_enable = 1'b1;
    sample_n(FLEN + 6);
    d = line_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL en_resume idx %0d tx_line=%0b expected %0b", d, obs_q[d], exp_at(d)); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    test_single_frame(8'h07);
    checks++;
    if (obs_q[9 * C] !== 1'b1) begin errors++; $display("FAIL parity_bit_07 got %0b expected 1", obs_q[9 * C]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame(8'hA5);
    test_single_frame(8'($urandom));
    test_back_to_back();
    test_drop();
    test_reset_mid_frame();
    test_enable();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
